// File: rtl/mcycle_if.sv
// Start/operand/result handshake between the decoder and the multi-cycle mul/div engine.
interface mcycle_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             Start;
    logic             MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, Done
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, Done
    );
endinterface

// File: rtl/mcycle_unit.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Busy stalls the pipeline from the Start cycle until the single-cycle Done pulse.
module mcycle_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic   CLK,
    input logic   RESETn,
    mcycle_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   fixed_q, fixed_d;   // multiplicand or divisor
    logic [WIDTH-1:0]   shift_q, shift_d;   // multiplier, or dividend turning into quotient
    logic [2*WIDTH-1:0] acc_q, acc_d;       // product, or partial remainder in [WIDTH:0]
    logic [WIDTH-1:0]   res1_q, res1_d, res2_q, res2_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0]   mul_shift;
    logic [WIDTH:0]     div_rem_sh;
    logic               div_ge;
    logic [WIDTH:0]     div_rem;
    logic [WIDTH-1:0]   div_quo;
    logic               accept;
    logic               last;

    always_comb begin
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (shift_q[0] ? {1'b0, fixed_q} : '0);
        mul_acc    = {mul_sum, acc_q[WIDTH-1:1]};
        mul_shift  = shift_q >> 1;
        div_rem_sh = {acc_q[WIDTH-1:0], shift_q[WIDTH-1]};
        div_ge     = div_rem_sh >= {1'b0, fixed_q};
        div_rem    = div_ge ? (div_rem_sh - {1'b0, fixed_q}) : div_rem_sh;
        div_quo    = {shift_q[WIDTH-2:0], div_ge};
    end

    assign accept = bus.Start && (state_q != StCompute);
    assign last   = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        fixed_d = fixed_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        res1_d  = res1_q;
        res2_d  = res2_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.Start) begin
                    state_d = StCompute;
                    cnt_d   = '0;
                    op_d    = bus.MCycleOp;
                    fixed_d = bus.MCycleOp ? bus.Operand2 : bus.Operand1;
                    shift_d = bus.MCycleOp ? bus.Operand1 : bus.Operand2;
                    acc_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StCompute: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q) begin
                    acc_d   = {{(WIDTH - 1){1'b0}}, div_rem};
                    shift_d = div_quo;
                end else begin
                    acc_d   = mul_acc;
                    shift_d = mul_shift;
                end
                // Results are committed only on entry to StDone, never mid-computation.
                if (last) begin
                    state_d = StDone;
                    res1_d  = op_q ? div_quo : mul_acc[WIDTH-1:0];
                    res2_d  = op_q ? div_rem[WIDTH-1:0] : mul_acc[2*WIDTH-1:WIDTH];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            fixed_q <= '0;
            shift_q <= '0;
            acc_q   <= '0;
            res1_q  <= '0;
            res2_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fixed_q <= fixed_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
        end
    end

    assign bus.Busy    = (state_q == StCompute) || accept;
    assign bus.Done    = (state_q == StDone);
    assign bus.Result1 = res1_q;
    assign bus.Result2 = res2_q;
endmodule

// File: tb/tb_mcycle_unit.sv
// Directed checks of mcycle_unit: mul/div results, latency, handshake, async reset, hold.
module tb_mcycle_unit;
    logic CLK;
    logic RESETn;
    int   total;
    int   bad;

    mcycle_if #(.WIDTH(32)) bus ();

    mcycle_unit #(.WIDTH(32)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
        bus.Start    = 1'b1;
        bus.MCycleOp = op;
        bus.Operand1 = a;
        bus.Operand2 = b;
    endtask

    // Called in the Start cycle; walks to the Done cycle counting Busy cycles.
    task automatic finish_op(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                             input bit poke);
        int busy_cnt;
        int done_idx;
        bit seen;
        busy_cnt = 0;
        done_idx = -1;
        seen     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.Busy) busy_cnt++;
            if (bus.Done && i > 0) begin
                seen     = 1'b1;
                done_idx = i;
                break;
            end
            @(posedge CLK);
            #1;
            bus.Start    = poke && (i == 4);
            bus.MCycleOp = ~bus.MCycleOp;
            bus.Operand1 = ~bus.Operand1 ^ 32'h1234_5678;
            bus.Operand2 = bus.Operand2 + 32'd3;
            @(negedge CLK);
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        check({tag, "_lat"}, 64'(done_idx), 64'd33);
        check({tag, "_busy"}, 64'(busy_cnt), 64'd33);
        check({tag, "_r1"}, 64'(bus.Result1), 64'(e1));
        check({tag, "_r2"}, 64'(bus.Result2), 64'(e2));
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        RESETn       = 1'b0;
        bus.Start    = 1'b0;
        bus.MCycleOp = 1'b0;
        bus.Operand1 = '0;
        bus.Operand2 = '0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_done", 64'(bus.Done), 64'd0);
        check("rst_r1", 64'(bus.Result1), 64'd0);
        check("rst_r2", 64'(bus.Result2), 64'd0);
        RESETn = 1'b1;

        @(negedge CLK); issue(1'b0, 32'd7, 32'd6);
        finish_op("mul_7x6", 32'd42, 32'd0, 1'b0);
        @(negedge CLK); issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("mul_max", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        @(negedge CLK); issue(1'b1, 32'd100, 32'd7);
        finish_op("div_100_7", 32'd14, 32'd2, 1'b0);
        @(negedge CLK); issue(1'b1, 32'd5, 32'd0);
        finish_op("div_by0", 32'hFFFF_FFFF, 32'd5, 1'b0);
        @(negedge CLK); issue(1'b0, 32'd1000, 32'd1000);
        finish_op("mul_poke", 32'd1_000_000, 32'd0, 1'b1);

        // Back-to-back: next Start raised in the Done cycle.
        @(negedge CLK); issue(1'b1, 32'd50, 32'd8);
        finish_op("div_50_8", 32'd6, 32'd2, 1'b0);
        issue(1'b1, 32'd9, 32'd2);
        #1;
        check("b2b_done", 64'(bus.Done), 64'd1);
        check("b2b_busy", 64'(bus.Busy), 64'd1);
        finish_op("div_9_2", 32'd4, 32'd1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            #1;
            check("hold_busy", 64'(bus.Busy), 64'd0);
            check("hold_done", 64'(bus.Done), 64'd0);
            check("hold_r1", 64'(bus.Result1), 64'd4);
            check("hold_r2", 64'(bus.Result2), 64'd1);
        end

        // Asynchronous reset in the middle of a multiply.
        @(negedge CLK); issue(1'b0, 32'hFFFF_FFFF, 32'd3);
        @(posedge CLK); #1; bus.Start = 1'b0;
        repeat (10) @(posedge CLK);
        #3;
        check("mid_busy", 64'(bus.Busy), 64'd1);
        RESETn = 1'b0;
        #1;
        check("arst_busy", 64'(bus.Busy), 64'd0);
        check("arst_done", 64'(bus.Done), 64'd0);
        check("arst_r1", 64'(bus.Result1), 64'd0);
        check("arst_r2", 64'(bus.Result2), 64'd0);
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK); issue(1'b0, 32'd3, 32'd3);
        finish_op("mul_3x3", 32'd9, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
